pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 255: data-memory wait cycles before a timeout is flagged.
REQ-002 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port hazard_hold_i  input  1  load-use hazard from the forward unit; combinational, same cycle.
REQ-005 Port jump_ena_i  input  1  branch/jump resolved taken in EX.
REQ-006 Port jump_addr_i  input  32  redirect target, qualified by jump_ena_i.
REQ-007 Port md_start_i  input  1  multi-cycle mul/div issued from EX.
REQ-008 Port md_done_i  input  1  mul/div result valid.
REQ-009 Port mem_req_i  input  1  MEM stage holds a load/store.
REQ-010 Port mem_ack_i  input  1  data memory completes the access.
REQ-011 Ports stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o  output  1 each  hold the PC / pipeline register.
REQ-012 Ports flush_if_id_o, flush_id_ex_o  output  1 each  load a bubble into the register.
REQ-013 Ports pc_w_ena_o (1) and pc_w_data_o (32)  output  PC redirect strobe and target.
REQ-014 Port state_o  output  2  current FSM state: RUN=0, MEM_WAIT=1, MD_WAIT=2, REDIRECT=3.
REQ-015 Ports stall_cnt_o (32) and mem_tmo_o (1)  output  saturating stall-cycle counter and sticky memory-timeout flag.

Function
REQ-016 In RUN with no event, all stall/flush/pc_w_ena outputs SHALL be 0.
REQ-017 Priority per cycle SHALL be: memory wait > mul/div wait > jump > load-use.
REQ-018 mem_req_i=1 and mem_ack_i=0 in RUN SHALL assert all five stalls that cycle and enter MEM_WAIT next edge.
REQ-019 In MEM_WAIT, stall_pc..stall_ex_mem SHALL be 1; stall_mem_wb SHALL be 0 and flush_id_ex SHALL be 0.
REQ-020 mem_ack_i=1 in MEM_WAIT SHALL release the stalls combinationally that cycle and exit next edge: to REDIRECT if a jump is pending, otherwise RUN.
REQ-021 A wait counter SHALL count MEM_WAIT cycles; on reaching MEM_WAIT_MAX, mem_tmo_o SHALL set and stay set until reset; the FSM still waits for mem_ack_i.
REQ-022 md_start_i=1 in RUN with no memory wait SHALL enter MD_WAIT next edge; in MD_WAIT, stall_pc, stall_if_id and stall_id_ex SHALL be 1 and flush of EX/MEM is not driven.
REQ-023 md_done_i=1 in MD_WAIT SHALL release the stalls that cycle and exit next edge, using the same REDIRECT rule as REQ-020; md_done_i in the same cycle as md_start_i SHALL not enter MD_WAIT.
REQ-024 jump_ena_i in RUN with no higher-priority event SHALL drive pc_w_ena_o=1, pc_w_data_o=jump_addr_i, flush_if_id_o=1 and flush_id_ex_o=1 in the same cycle, with zero latency.
REQ-025 jump_ena_i while a stall is active or being entered SHALL capture jump_addr_i into a pending register (first capture wins); a second jump before release SHALL be ignored.
REQ-026 REDIRECT SHALL last exactly one cycle, applying REQ-024 with the pending address, clearing the pending flag and returning to RUN.
REQ-027 hazard_hold_i in RUN with no other event SHALL drive stall_pc=1, stall_if_id=1 and flush_id_ex=1 for that cycle only; it is ignored when a jump occurs in the same cycle, because the flush wins.
REQ-028 stall_cnt_o SHALL increment on every cycle in which stall_pc_o=1 and saturate at 0xFFFF_FFFF.
REQ-029 pc_w_data_o SHALL be 0 whenever pc_w_ena_o=0.

Reset
REQ-030 rst=1 SHALL asynchronously force state RUN, clear the pending jump, wait counter, stall_cnt_o and mem_tmo_o, and drive every output to 0.
REQ-031 Reset mid-MEM_WAIT or mid-MD_WAIT SHALL discard the pending jump; after release the first cycle SHALL be RUN with no outputs asserted.

Structure
REQ-032 State encodings and the 32-bit address width SHALL live in define.v.
REQ-033 pipe_ctrl SHALL be one module containing a registered FSM, the pending-jump register and the counters, with combinational output decode.
REQ-034 One sub-module, sat_cnt (a parameterised saturating counter), SHALL be used for stall_cnt and the wait counter.

Verification
REQ-035 Scenario: hazard_hold_i for 1 cycle -> stall_pc=stall_if_id=flush_id_ex=1 for exactly that cycle, and stall_cnt_o=1.
REQ-036 Scenario: jump_ena_i with jump_addr_i=0x0000_0100 in RUN -> pc_w_ena=1, pc_w_data=0x100, both flushes=1 in the same cycle.
REQ-037 Scenario: mem_req_i with mem_ack_i delayed 3 cycles, jump to 0x200 asserted in wait cycle 1 -> 4 stall cycles, then one REDIRECT cycle with pc_w_data=0x200, then RUN.
REQ-038 Scenario: md_start_i, then md_done_i 5 cycles later, with hazard_hold_i held high throughout -> MD_WAIT for 5 cycles and no flush_id_ex during MD_WAIT.
REQ-039 Scenario: MEM_WAIT_MAX=4 and mem_ack_i withheld for 10 cycles -> mem_tmo_o rises after the 4th wait cycle and stays high after the ack.
REQ-040 Scenario: rst pulsed during MD_WAIT with a pending jump -> outputs 0 immediately, state_o=0, and no REDIRECT after reset release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Pipeline control shared definitions: FSM state encoding, address width,
// and the packed bundle of per-cycle stall/flush/redirect controls.
package pipe_ctrl_pkg;

  localparam int ADDR_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // MSB first: matches the order the stall/flush ports are listed in.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic pc_w_ena;
  } ctl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline and its controller.
//   master: pipeline side (drives hazard/jump/mul-div/memory status)
//   slave : pipe_ctrl (drives stalls, flushes, PC redirect, status)
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic  hazard_hold_i;
  logic  jump_ena_i;
  addr_t jump_addr_i;
  logic  md_start_i;
  logic  md_done_i;
  logic  mem_req_i;
  logic  mem_ack_i;

  logic        stall_pc_o;
  logic        stall_if_id_o;
  logic        stall_id_ex_o;
  logic        stall_ex_mem_o;
  logic        stall_mem_wb_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        pc_w_ena_o;
  addr_t       pc_w_data_o;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt_o;
  logic        mem_tmo_o;

  modport master (
    output hazard_hold_i, jump_ena_i, jump_addr_i, md_start_i, md_done_i,
           mem_req_i, mem_ack_i,
    input  stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
           stall_mem_wb_o, flush_if_id_o, flush_id_ex_o, pc_w_ena_o,
           pc_w_data_o, state_o, stall_cnt_o, mem_tmo_o
  );

  modport slave (
    input  hazard_hold_i, jump_ena_i, jump_addr_i, md_start_i, md_done_i,
           mem_req_i, mem_ack_i,
    output stall_pc_o, stall_if_id_o, stall_id_ex_o, stall_ex_mem_o,
           stall_mem_wb_o, flush_if_id_o, flush_id_ex_o, pc_w_ena_o,
           pc_w_data_o, state_o, stall_cnt_o, mem_tmo_o
  );

endinterface

// File: rtl/pipe_ctrl_sat_cnt.sv
// sat_cnt: W-bit up-counter that sticks at all-ones.
//   clk, rst : clock, async active-high reset (count -> 0)
//   clr      : synchronous clear, wins over inc
//   inc      : count up by one unless saturated
//   cnt_o    : current count
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (inc && cnt_q != '1)  cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/stall/flush controller.
//   clk, rst : clock, async active-high reset
//   bus      : pipe_ctrl_if.slave -- hazard, jump, mul/div and memory status
//              in; per-stage stalls, flushes, PC redirect, FSM state, stall
//              cycle counter and sticky memory-timeout flag out.
// Per-cycle priority in RUN: memory wait > mul/div wait > jump > load-use.
// A jump seen while a stall is active (or being entered) is parked in a
// one-deep pending register and replayed in a single REDIRECT cycle.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int              WCW    = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WCW-1:0]  TMO_AT = WCW'(MEM_WAIT_MAX - 1);

  state_e         state_q, state_d;
  logic           pend_q, pend_d;
  addr_t          pend_addr_q, pend_addr_d;
  logic           tmo_q, tmo_d;
  logic [WCW-1:0] wait_cnt;
  logic [31:0]    stall_cnt;
  ctl_t           ctl;
  addr_t          pc_w_data;

  logic mem_wait, md_go, cap_en;

  assign mem_wait = bus.mem_req_i & ~bus.mem_ack_i;
  // Start and done together means a zero-latency op: nothing to wait for.
  assign md_go    = bus.md_start_i & ~bus.md_done_i;
  // Jumps are parked whenever they cannot be applied this cycle, including
  // the release cycle of a wait so the redirect follows the release.
  assign cap_en   = ((state_q == ST_RUN) & (mem_wait | md_go)) |
                    (state_q == ST_MEM_WAIT) | (state_q == ST_MD_WAIT);

  // ---------------- state / pending / timeout registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      tmo_q       <= tmo_d;
    end
  end

  // ---------------- pending jump (first capture wins) ----------------
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (state_q == ST_REDIRECT) begin
      pend_d = 1'b0;
    end else if (cap_en && bus.jump_ena_i && !pend_q) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.jump_addr_i;
    end
  end

  // Sets on the edge that completes the MEM_WAIT_MAX-th wait cycle.
  always_comb begin
    tmo_d = tmo_q | ((state_q == ST_MEM_WAIT) && (wait_cnt == TMO_AT));
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait)   state_d = ST_MEM_WAIT;
        else if (md_go) state_d = ST_MD_WAIT;
      end
      ST_MEM_WAIT: if (bus.mem_ack_i) state_d = pend_d ? ST_REDIRECT : ST_RUN;
      ST_MD_WAIT:  if (bus.md_done_i) state_d = pend_d ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    ctl       = '0;
    pc_w_data = '0;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          ctl.stall_pc     = 1'b1;
          ctl.stall_if_id  = 1'b1;
          ctl.stall_id_ex  = 1'b1;
          ctl.stall_ex_mem = 1'b1;
          ctl.stall_mem_wb = 1'b1;
        end else if (md_go) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_if_id = 1'b1;
          ctl.stall_id_ex = 1'b1;
        end else if (bus.jump_ena_i) begin
          // Flush already bubbles ID/EX, so a same-cycle load-use is moot.
          ctl.pc_w_ena    = 1'b1;
          ctl.flush_if_id = 1'b1;
          ctl.flush_id_ex = 1'b1;
          pc_w_data       = bus.jump_addr_i;
        end else if (bus.hazard_hold_i) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_if_id = 1'b1;
          ctl.flush_id_ex = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        // MEM/WB drains so the writeback of older results completes.
        if (!bus.mem_ack_i) begin
          ctl.stall_pc     = 1'b1;
          ctl.stall_if_id  = 1'b1;
          ctl.stall_id_ex  = 1'b1;
          ctl.stall_ex_mem = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        if (!bus.md_done_i) begin
          ctl.stall_pc    = 1'b1;
          ctl.stall_if_id = 1'b1;
          ctl.stall_id_ex = 1'b1;
        end
      end
      ST_REDIRECT: begin
        ctl.pc_w_ena    = 1'b1;
        ctl.flush_if_id = 1'b1;
        ctl.flush_id_ex = 1'b1;
        pc_w_data       = pend_addr_q;
      end
      default: ;
    endcase
    // Inputs may still be active while reset is held; keep outputs quiet.
    if (rst) begin
      ctl       = '0;
      pc_w_data = '0;
    end
  end

  // ---------------- counters ----------------
  sat_cnt #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (ctl.stall_pc),
    .cnt_o (stall_cnt)
  );

  // Restarts from zero on every entry to MEM_WAIT.
  sat_cnt #(.W(WCW)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q != ST_MEM_WAIT),
    .inc   (state_q == ST_MEM_WAIT),
    .cnt_o (wait_cnt)
  );

  assign bus.stall_pc_o     = ctl.stall_pc;
  assign bus.stall_if_id_o  = ctl.stall_if_id;
  assign bus.stall_id_ex_o  = ctl.stall_id_ex;
  assign bus.stall_ex_mem_o = ctl.stall_ex_mem;
  assign bus.stall_mem_wb_o = ctl.stall_mem_wb;
  assign bus.flush_if_id_o  = ctl.flush_if_id;
  assign bus.flush_id_ex_o  = ctl.flush_id_ex;
  assign bus.pc_w_ena_o     = ctl.pc_w_ena;
  assign bus.pc_w_data_o    = pc_w_data;
  assign bus.state_o        = state_q;
  assign bus.stall_cnt_o    = stall_cnt;
  assign bus.mem_tmo_o      = tmo_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Two instances: default MEM_WAIT_MAX for the
// functional scenarios, MEM_WAIT_MAX=4 for the timeout scenario.
// Inputs change 1ns after the rising edge; outputs are sampled on the
// falling edge. ctl vectors are {stall pc,if_id,id_ex,ex_mem,mem_wb,
// flush if_id,id_ex, pc_w_ena}.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] C_IDLE = 8'b00000_000;
  localparam logic [7:0] C_ALL  = 8'b11111_000;
  localparam logic [7:0] C_MEMW = 8'b11110_000;
  localparam logic [7:0] C_MD   = 8'b11100_000;
  localparam logic [7:0] C_JMP  = 8'b00000_111;
  localparam logic [7:0] C_HAZ  = 8'b11000_010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl_if bus4 ();

  pipe_ctrl #(.MEM_WAIT_MAX(255)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  pipe_ctrl #(.MEM_WAIT_MAX(4))   dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  logic [7:0] ctl, ctl4;
  assign ctl  = {bus.stall_pc_o, bus.stall_if_id_o, bus.stall_id_ex_o,
                 bus.stall_ex_mem_o, bus.stall_mem_wb_o, bus.flush_if_id_o,
                 bus.flush_id_ex_o, bus.pc_w_ena_o};
  assign ctl4 = {bus4.stall_pc_o, bus4.stall_if_id_o, bus4.stall_id_ex_o,
                 bus4.stall_ex_mem_o, bus4.stall_mem_wb_o, bus4.flush_if_id_o,
                 bus4.flush_id_ex_o, bus4.pc_w_ena_o};

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.hazard_hold_i  = 1'b0; bus.jump_ena_i  = 1'b0; bus.jump_addr_i  = '0;
    bus.md_start_i     = 1'b0; bus.md_done_i   = 1'b0;
    bus.mem_req_i      = 1'b0; bus.mem_ack_i   = 1'b0;
    bus4.hazard_hold_i = 1'b0; bus4.jump_ena_i = 1'b0; bus4.jump_addr_i = '0;
    bus4.md_start_i    = 1'b0; bus4.md_done_i  = 1'b0;
    bus4.mem_req_i     = 1'b0; bus4.mem_ack_i  = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    int mdw;
    idle_in();
    rst = 1'b1;
    // Reset state, with a jump request present to show outputs stay quiet.
    bus.jump_ena_i = 1'b1; bus.jump_addr_i = 32'h0000_0AAA;
    #2;
    chk("rst_ctl",   ctl, C_IDLE);
    chk("rst_data",  bus.pc_w_data_o, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_cnt",   bus.stall_cnt_o, 0);
    chk("rst_tmo",   bus.mem_tmo_o, 0);
    do_reset();

    // Load-use hazard for one cycle.
    bus.hazard_hold_i = 1'b1;
    smp(); chk("haz_ctl", ctl, C_HAZ);
    nxt(); bus.hazard_hold_i = 1'b0;
    smp(); chk("haz_off", ctl, C_IDLE); chk("haz_cnt", bus.stall_cnt_o, 1);
    nxt();

    // Jump in RUN; concurrent hazard is swallowed by the flush.
    do_reset();
    bus.jump_ena_i = 1'b1; bus.jump_addr_i = 32'h0000_0100; bus.hazard_hold_i = 1'b1;
    smp(); chk("jmp_ctl", ctl, C_JMP); chk("jmp_data", bus.pc_w_data_o, 32'h100);
    chk("jmp_state", bus.state_o, 0);
    nxt(); bus.jump_ena_i = 1'b0; bus.hazard_hold_i = 1'b0;
    smp(); chk("jmp_off_data", bus.pc_w_data_o, 0); chk("jmp_off_ctl", ctl, C_IDLE);
    nxt();

    // Memory wait, jump in wait cycle 1, second jump ignored, ack after 3.
    do_reset();
    bus.mem_req_i = 1'b1;
    smp(); chk("mw0_ctl", ctl, C_ALL); chk("mw0_state", bus.state_o, 0);
    nxt(); bus.jump_ena_i = 1'b1; bus.jump_addr_i = 32'h0000_0200;
    smp(); chk("mw1_ctl", ctl, C_MEMW); chk("mw1_state", bus.state_o, 1);
    nxt(); bus.jump_addr_i = 32'h0000_0999;
    smp(); chk("mw2_ctl", ctl, C_MEMW);
    nxt(); bus.jump_ena_i = 1'b0;
    smp(); chk("mw3_ctl", ctl, C_MEMW);
    nxt(); bus.mem_ack_i = 1'b1;
    smp(); chk("mw4_ctl", ctl, C_IDLE); chk("mw4_state", bus.state_o, 1);
    nxt(); bus.mem_req_i = 1'b0; bus.mem_ack_i = 1'b0;
    smp(); chk("rd_state", bus.state_o, 3); chk("rd_ctl", ctl, C_JMP);
    chk("rd_data", bus.pc_w_data_o, 32'h200);
    nxt();
    smp(); chk("rd_after_state", bus.state_o, 0); chk("rd_after_ctl", ctl, C_IDLE);
    chk("mw_cnt", bus.stall_cnt_o, 4);
    nxt();

    // Mul/div with hazard held high throughout; done 5 cycles after start.
    do_reset();
    bus.md_start_i = 1'b1; bus.hazard_hold_i = 1'b1;
    smp(); chk("md0_ctl", ctl, C_MD); chk("md0_state", bus.state_o, 0);
    nxt(); bus.md_start_i = 1'b0;
    mdw = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) bus.md_done_i = 1'b1;
      smp();
      if (bus.state_o == 2'd2) mdw++;
      chk($sformatf("md%0d_flush", i), bus.flush_id_ex_o, 0);
      chk($sformatf("md%0d_ctl", i), ctl, (i < 5) ? C_MD : C_IDLE);
      nxt();
    end
    bus.md_done_i = 1'b0;
    smp(); chk("md_cycles", mdw, 5); chk("md_end_state", bus.state_o, 0);
    chk("md_end_haz", ctl, C_HAZ);
    nxt(); bus.hazard_hold_i = 1'b0;

    // Start and done together: no wait state.
    do_reset();
    bus.md_start_i = 1'b1; bus.md_done_i = 1'b1;
    smp(); chk("md_same_ctl", ctl, C_IDLE);
    nxt(); idle_in();
    smp(); chk("md_same_state", bus.state_o, 0);
    nxt();

    // Memory wait beats jump and hazard in the same cycle; jump replays.
    do_reset();
    bus.mem_req_i = 1'b1; bus.jump_ena_i = 1'b1; bus.jump_addr_i = 32'h0000_0400;
    bus.hazard_hold_i = 1'b1;
    smp(); chk("pri_ctl", ctl, C_ALL);
    nxt(); bus.mem_ack_i = 1'b1; bus.jump_ena_i = 1'b0; bus.hazard_hold_i = 1'b0;
    smp(); chk("pri_rel", ctl, C_IDLE);
    nxt(); idle_in();
    smp(); chk("pri_rd_state", bus.state_o, 3); chk("pri_rd_data", bus.pc_w_data_o, 32'h400);
    nxt();
    smp(); chk("pri_run", bus.state_o, 0);
    nxt();

    // Timeout with MEM_WAIT_MAX=4, ack withheld for 10 wait cycles.
    do_reset();
    bus4.mem_req_i = 1'b1;
    smp(); chk("tmo0_ctl", ctl4, C_ALL);
    nxt();
    for (int w = 1; w <= 10; w++) begin
      smp();
      chk($sformatf("tmo_w%0d_state", w), bus4.state_o, 1);
      chk($sformatf("tmo_w%0d_flag", w), bus4.mem_tmo_o, (w >= 5) ? 1 : 0);
      nxt();
    end
    bus4.mem_ack_i = 1'b1;
    smp(); chk("tmo_ack_ctl", ctl4, C_IDLE);
    nxt(); bus4.mem_req_i = 1'b0; bus4.mem_ack_i = 1'b0;
    smp(); chk("tmo_after_state", bus4.state_o, 0); chk("tmo_sticky", bus4.mem_tmo_o, 1);
    nxt();

    // Reset during MD_WAIT with a pending jump.
    do_reset();
    bus.md_start_i = 1'b1;
    nxt(); bus.md_start_i = 1'b0; bus.jump_ena_i = 1'b1; bus.jump_addr_i = 32'h0000_0300;
    smp(); chk("rmd_state", bus.state_o, 2);
    nxt();
    rst = 1'b1;       // mid-cycle, jump still requested
    #1;
    chk("rmd_ctl", ctl, C_IDLE); chk("rmd_data", bus.pc_w_data_o, 0);
    chk("rmd_state0", bus.state_o, 0); chk("rmd_cnt", bus.stall_cnt_o, 0);
    nxt(); rst = 1'b0; idle_in();
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("rmd_post%0d_state", k), bus.state_o, 0);
      chk($sformatf("rmd_post%0d_ctl", k), ctl, C_IDLE);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
